// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush sequencer for the 5-stage core
//
// Arbitrates data-memory wait, multi-cycle execute ops, taken-branch redirect
// and load-use stall into one set of per-stage stall/flush controls. A small
// IDLE/MC state machine with a down-counter holds a multi-cycle op in E for
// MC_LAT cycles, not counting cycles lost to memory wait.
//
// Optional feature macro: PIPE_CTRL_PERF_EN (adds stall/flush perf counters).
//
// Ports:
//   clk            in   core clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   lwstall        in   load-use stall request
//   mcStartE       in   instruction in E is a multi-cycle op
//   branchTakenE   in   taken branch/jump resolved in E
//   memReqM        in   M-stage instruction accesses data memory
//   memReadyM      in   data memory completes the access this cycle
//   stallF..stallM out  hold the corresponding pipeline register
//   flushD..flushW out  load a bubble into the corresponding pipeline register
//   mcBusy         out  state machine is in MC
//   mcDone         out  pulse in the final cycle of a multi-cycle op
//   perfClr        in   (PIPE_CTRL_PERF_EN) synchronous clear of both counters
//   stallCnt       out  (PIPE_CTRL_PERF_EN) cycles with stallF=1
//   flushCnt       out  (PIPE_CTRL_PERF_EN) cycles with flushD|flushE

module pipe_ctrl #(
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lwstall,
    input  logic        mcStartE,
    input  logic        branchTakenE,
    input  logic        memReqM,
    input  logic        memReadyM,
    output logic        stallF,
    output logic        stallD,
    output logic        stallE,
    output logic        stallM,
    output logic        flushD,
    output logic        flushE,
    output logic        flushM,
    output logic        flushW,
    output logic        mcBusy,
`ifdef PIPE_CTRL_PERF_EN
    input  logic        perfClr,
    output logic [31:0] stallCnt,
    output logic [31:0] flushCnt,
`endif
    output logic        mcDone
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MC   = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(MC_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mem_stall;

    assign mem_stall = memReqM & ~memReadyM;

    // Priority: memory wait, then an op already in MC, then a new op start,
    // then branch redirect, then load-use. Outputs are forced low while reset
    // is asserted so the pipeline sees no controls during reset.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stallF  = 1'b0;
        stallD  = 1'b0;
        stallE  = 1'b0;
        stallM  = 1'b0;
        flushD  = 1'b0;
        flushE  = 1'b0;
        flushM  = 1'b0;
        flushW  = 1'b0;
        mcDone  = 1'b0;
        if (rst_n) begin
            if (mem_stall) begin
                // Whole pipe holds; W gets a bubble because M cannot retire.
                // State and counter freeze, so each wait cycle adds one cycle.
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
                flushW = 1'b1;
            end else if (state_q == ST_MC) begin
                if (cnt_q > CNT_ONE) begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    stallE = 1'b1;
                    flushM = 1'b1;
                    cnt_d  = cnt_q - CNT_ONE;
                end else begin
                    // Final cycle: the op leaves E at this edge.
                    mcDone  = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end else if (mcStartE) begin
                // The start cycle itself counts as the first of MC_LAT.
                stallF  = 1'b1;
                stallD  = 1'b1;
                stallE  = 1'b1;
                flushM  = 1'b1;
                state_d = ST_MC;
                cnt_d   = CNT_START;
            end else if (branchTakenE) begin
                // D holds a wrong-path instruction, so a load-use request
                // against it is meaningless and dropped.
                flushD = 1'b1;
                flushE = 1'b1;
            end else if (lwstall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end
        end
    end

    assign mcBusy = rst_n & (state_q == ST_MC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (perfClr) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stallF) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flushD | flushE) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stallCnt = stall_cnt_q;
    assign flushCnt = flush_cnt_q;
`endif

`ifndef SYNTHESIS
    // A multi-cycle op and a taken branch cannot both be resolved in E.
    a_no_mc_and_branch : assert property (
        @(posedge clk) disable iff (!rst_n)
        !(mcStartE && branchTakenE)
    ) else $error("pipe_ctrl: mcStartE and branchTakenE asserted together");
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl

module tb_pipe_ctrl;

    logic clk;
    logic rst_n;
    logic lwstall;
    logic mcStartE;
    logic branchTakenE;
    logic memReqM;
    logic memReadyM;
    logic stallF, stallD, stallE, stallM;
    logic flushD, flushE, flushM, flushW;
    logic mcBusy, mcDone;
`ifdef PIPE_CTRL_PERF_EN
    logic        perfClr;
    logic [31:0] stallCnt;
    logic [31:0] flushCnt;
`endif

    int total;
    int bad;

    pipe_ctrl #(.MC_LAT(4), .CNT_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lwstall      (lwstall),
        .mcStartE     (mcStartE),
        .branchTakenE (branchTakenE),
        .memReqM      (memReqM),
        .memReadyM    (memReadyM),
        .stallF       (stallF),
        .stallD       (stallD),
        .stallE       (stallE),
        .stallM       (stallM),
        .flushD       (flushD),
        .flushE       (flushE),
        .flushM       (flushM),
        .flushW       (flushW),
        .mcBusy       (mcBusy),
`ifdef PIPE_CTRL_PERF_EN
        .perfClr      (perfClr),
        .stallCnt     (stallCnt),
        .flushCnt     (flushCnt),
`endif
        .mcDone       (mcDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {stallF,stallD,stallE,stallM,flushD,flushE,flushM,flushW,mcBusy,mcDone}
    logic [9:0] outs;
    assign outs = {stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW, mcBusy, mcDone};

    localparam logic [9:0] O_ZERO     = 10'b0000000000;
    localparam logic [9:0] O_MC_START = 10'b1110001000;
    localparam logic [9:0] O_MC_HOLD  = 10'b1110001010;
    localparam logic [9:0] O_MC_DONE  = 10'b0000000011;
    localparam logic [9:0] O_MEM_IDLE = 10'b1111000100;
    localparam logic [9:0] O_MEM_MC   = 10'b1111000110;
    localparam logic [9:0] O_BRANCH   = 10'b0000110000;
    localparam logic [9:0] O_LW       = 10'b1100010000;

    task automatic clear_inputs();
        lwstall      = 1'b0;
        mcStartE     = 1'b0;
        branchTakenE = 1'b0;
        memReqM      = 1'b0;
        memReadyM    = 1'b0;
`ifdef PIPE_CTRL_PERF_EN
        perfClr      = 1'b0;
`endif
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        lwstall      = 1'b1;
        mcStartE     = 1'b1;
        branchTakenE = 1'b1;
        memReqM      = 1'b1;
        memReadyM    = 1'b1;
`ifdef PIPE_CTRL_PERF_EN
        perfClr      = 1'b1;
`endif
        @(negedge clk);
        total++;
        if (outs !== O_ZERO) begin
            bad++;
            $display("FAIL reset_outputs: got %b want %b", outs, O_ZERO);
        end
        next_cycle();
        clear_inputs();
        rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        total++;
        if (outs !== O_ZERO) begin
            bad++;
            $display("FAIL reset_release_idle: got %b want %b", outs, O_ZERO);
        end
        next_cycle();
    endtask

    task automatic test_multicycle();
        logic [9:0] exp [5];
        exp[0] = O_MC_START;
        exp[1] = O_MC_HOLD;
        exp[2] = O_MC_HOLD;
        exp[3] = O_MC_DONE;
        exp[4] = O_ZERO;
        for (int c = 0; c < 5; c++) begin
            mcStartE = (c == 0);
            @(negedge clk);
            total++;
            if (outs !== exp[c]) begin
                bad++;
                $display("FAIL multicycle_c%0d: got %b want %b", c, outs, exp[c]);
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_mem_in_mc();
        logic [9:0] exp [7];
        exp[0] = O_MC_START;
        exp[1] = O_MEM_MC;
        exp[2] = O_MEM_MC;
        exp[3] = O_MC_HOLD;
        exp[4] = O_MC_HOLD;
        exp[5] = O_MC_DONE;
        exp[6] = O_ZERO;
        for (int c = 0; c < 7; c++) begin
            mcStartE  = (c == 0);
            memReqM   = (c == 1 || c == 2);
            memReadyM = 1'b0;
            @(negedge clk);
            total++;
            if (outs !== exp[c]) begin
                bad++;
                $display("FAIL mem_in_mc_c%0d: got %b want %b", c, outs, exp[c]);
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    // Start held off by memory wait in IDLE, then a wait on the final cycle
    // defers mcDone.
    task automatic test_mem_edges();
        logic [9:0] exp [7];
        logic       mem [7];
        exp[0] = O_MEM_IDLE;  mem[0] = 1'b1;
        exp[1] = O_MC_START;  mem[1] = 1'b0;
        exp[2] = O_MC_HOLD;   mem[2] = 1'b0;
        exp[3] = O_MC_HOLD;   mem[3] = 1'b0;
        exp[4] = O_MEM_MC;    mem[4] = 1'b1;
        exp[5] = O_MC_DONE;   mem[5] = 1'b0;
        exp[6] = O_ZERO;      mem[6] = 1'b0;
        for (int c = 0; c < 7; c++) begin
            mcStartE  = (c <= 1);
            memReqM   = mem[c];
            memReadyM = (c == 6);
            @(negedge clk);
            total++;
            if (outs !== exp[c]) begin
                bad++;
                $display("FAIL mem_edges_c%0d: got %b want %b", c, outs, exp[c]);
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_branch_lw();
        branchTakenE = 1'b1;
        lwstall      = 1'b1;
        @(negedge clk);
        total++;
        if (outs !== O_BRANCH) begin
            bad++;
            $display("FAIL branch_vs_lw: got %b want %b", outs, O_BRANCH);
        end
        next_cycle();
        clear_inputs();
        lwstall = 1'b1;
        @(negedge clk);
        total++;
        if (outs !== O_LW) begin
            bad++;
            $display("FAIL lone_lwstall: got %b want %b", outs, O_LW);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_mc_ignores();
        mcStartE = 1'b1;
        next_cycle();
        mcStartE     = 1'b0;
        branchTakenE = 1'b1;
        lwstall      = 1'b1;
        @(negedge clk);
        total++;
        if (outs !== O_MC_HOLD) begin
            bad++;
            $display("FAIL mc_ignores: got %b want %b", outs, O_MC_HOLD);
        end
        next_cycle();
        clear_inputs();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp [6];
        exp[0] = O_MC_START;
        exp[1] = O_MC_HOLD;
        exp[2] = O_MC_HOLD;
        exp[3] = O_MC_DONE;
        exp[4] = O_MC_START;
        exp[5] = O_MC_HOLD;
        mcStartE = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            total++;
            if (outs !== exp[c]) begin
                bad++;
                $display("FAIL back_to_back_c%0d: got %b want %b", c, outs, exp[c]);
            end
            next_cycle();
        end
        clear_inputs();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_reset_mid();
        mcStartE = 1'b1;
        next_cycle();
        mcStartE = 1'b0;
        next_cycle();
        rst_n = 1'b0;
        #1;
        total++;
        if (outs !== O_ZERO) begin
            bad++;
            $display("FAIL reset_mid_async: got %b want %b", outs, O_ZERO);
        end
        next_cycle();
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++;
            if (outs !== O_ZERO) begin
                bad++;
                $display("FAIL reset_mid_after_c%0d: got %b want %b", c, outs, O_ZERO);
            end
            next_cycle();
        end
`ifdef PIPE_CTRL_PERF_EN
        total++;
        if (stallCnt !== 32'd0) begin
            bad++;
            $display("FAIL perf_after_reset: got %0d want 0", stallCnt);
        end
        lwstall = 1'b1;
        next_cycle();
        next_cycle();
        next_cycle();
        lwstall = 1'b0;
        branchTakenE = 1'b1;
        next_cycle();
        branchTakenE = 1'b0;
        total++;
        if (stallCnt !== 32'd3) begin
            bad++;
            $display("FAIL perf_stall_count: got %0d want 3", stallCnt);
        end
        total++;
        if (flushCnt !== 32'd4) begin
            bad++;
            $display("FAIL perf_flush_count: got %0d want 4", flushCnt);
        end
        lwstall = 1'b1;
        perfClr = 1'b1;
        next_cycle();
        clear_inputs();
        total++;
        if (stallCnt !== 32'd0) begin
            bad++;
            $display("FAIL perf_clear_priority: got %0d want 0", stallCnt);
        end
`endif
        clear_inputs();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_multicycle();
        test_mem_in_mc();
        test_mem_edges();
        test_branch_lw();
        test_mc_ignores();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
